// File: rtl/counter_ctrl.sv
// -----------------------------------------------------------------------------
// counter_ctrl - front-panel control stage for the 8-bit up/down counter.
//
// Conditions four raw push-buttons (2-FF sync, debounce, press detect), runs
// an IDLE/RUN/PAUSE state machine and auto-pauses the counter when it reaches
// UP_LIMIT (counting up) or DN_LIMIT (counting down).
//
// Optional feature: define COUNTER_CTRL_STEP_EN to add a btn_step input that
// single-steps the counter while paused.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before a synchronised level is accepted (>=1)
//   UP_LIMIT         count value at which up-counting auto-pauses
//   DN_LIMIT         count value at which down-counting auto-pauses (< UP_LIMIT)
//
// Ports:
//   clk         system clock, rising edge
//   rstn        asynchronous active-low reset
//   btn_start   raw button: IDLE->RUN, or resume from PAUSE
//   btn_stop    raw button: return to IDLE (clears the counter)
//   btn_pause   raw button: toggles RUN/PAUSE
//   btn_dir     raw button: toggles count direction
//   btn_step    raw button: one count while paused (COUNTER_CTRL_STEP_EN only)
//   cnt         counter value fed back from the counter
//   ena         counter enable, 0 clears the counter
//   up_down     1 = count up, 0 = count down
//   hold        1 = counter holds its value
//   limit_flag  sticky auto-pause indicator
//   state       00 IDLE, 01 RUN, 10 PAUSE
// -----------------------------------------------------------------------------

// Per-button conditioning: synchroniser, debouncer and press-event detector.
//   raw    asynchronous active-high button input
//   press  one-cycle pulse on an accepted 0->1 debounced transition
module counter_ctrl_btn #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic raw,
    output logic press
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync;
    logic [1:0]    vld_pipe;   // tracks when sync[1] holds real input data
    logic [CW-1:0] db_cnt;
    logic          level;
    logic          level_d;
    logic          armed;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync     <= '0;
            vld_pipe <= '0;
            db_cnt   <= '0;
            level    <= 1'b0;
            level_d  <= 1'b0;
            armed    <= 1'b0;
        end else begin
            sync     <= {sync[0], raw};
            vld_pipe <= {vld_pipe[0], 1'b1};
            level_d  <= level;
            // A button held through reset must be seen released before its
            // next rising edge counts as a press.
            if (vld_pipe[1] && !sync[1])
                armed <= 1'b1;
            // Count consecutive cycles of disagreement; any agreement restarts.
            if (sync[1] != level) begin
                if (db_cnt == CNT_LAST) begin
                    level  <= sync[1];
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = level & ~level_d & armed;
endmodule

module counter_ctrl #(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter logic [7:0] UP_LIMIT        = 8'd255,
    parameter logic [7:0] DN_LIMIT        = 8'd0
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_pause,
    input  logic       btn_dir,
`ifdef COUNTER_CTRL_STEP_EN
    input  logic       btn_step,
`endif
    input  logic [7:0] cnt,
    output logic       ena,
    output logic       up_down,
    output logic       hold,
    output logic       limit_flag,
    output logic [1:0] state
);
`ifdef COUNTER_CTRL_STEP_EN
    localparam int NUM_BTN = 5;
`else
    localparam int NUM_BTN = 4;
`endif
    localparam int B_START = 0;
    localparam int B_STOP  = 1;
    localparam int B_PAUSE = 2;
    localparam int B_DIR   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_PAUSE = 2'b10
    } state_t;

    state_t             state_q;
    logic [NUM_BTN-1:0] raw_btn;
    logic [NUM_BTN-1:0] ev;

`ifdef COUNTER_CTRL_STEP_EN
    assign raw_btn = {btn_step, btn_dir, btn_pause, btn_stop, btn_start};
`else
    assign raw_btn = {btn_dir, btn_pause, btn_stop, btn_start};
`endif

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            counter_ctrl_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
                .clk   (clk),
                .rstn  (rstn),
                .raw   (raw_btn[g]),
                .press (ev[g])
            );
        end
    endgenerate

    logic ev_start, ev_stop, ev_pause;
    logic dir_act, ud_new;
    logic at_lim_cur, at_lim_new, limit_hit;

    always_comb begin
        ev_start   = ev[B_START];
        ev_stop    = ev[B_STOP];
        ev_pause   = ev[B_PAUSE];
        // Dir rides along with start/pause but is swallowed by stop.
        dir_act    = ev[B_DIR] & ~ev[B_STOP];
        ud_new     = up_down ^ dir_act;
        at_lim_cur = up_down ? (cnt == UP_LIMIT) : (cnt == DN_LIMIT);
        // Resume is judged in the direction it will actually run.
        at_lim_new = ud_new  ? (cnt == UP_LIMIT) : (cnt == DN_LIMIT);
        // Look one count ahead so hold lands as cnt reaches the limit.
        limit_hit  = up_down ? ((cnt == UP_LIMIT - 8'd1) || (cnt == UP_LIMIT))
                             : ((cnt == DN_LIMIT + 8'd1) || (cnt == DN_LIMIT));
    end

`ifdef COUNTER_CTRL_STEP_EN
    logic step_ev;
    // Step is the lowest priority: any other event in the cycle drops it.
    assign step_ev = ev[4] & ~|ev[3:0];
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            ena        <= 1'b0;
            up_down    <= 1'b1;
            hold       <= 1'b0;
            limit_flag <= 1'b0;
        end else begin
            if (dir_act) begin
                up_down    <= ud_new;
                limit_flag <= 1'b0;
            end
            if (ev_stop) begin
                state_q    <= S_IDLE;
                ena        <= 1'b0;
                hold       <= 1'b0;
                limit_flag <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (ev_start) begin
                            state_q <= S_RUN;
                            ena     <= 1'b1;
                            hold    <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        // A dir toggle in the same cycle overrides auto-pause.
                        if ((ev_pause && !ev_start) || (limit_hit && !dir_act)) begin
                            state_q <= S_PAUSE;
                            hold    <= 1'b1;
                            if (limit_hit && !dir_act)
                                limit_flag <= 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if ((ev_start || ev_pause) && !at_lim_new) begin
                            state_q <= S_RUN;
                            hold    <= 1'b0;
                        end
`ifdef COUNTER_CTRL_STEP_EN
                        // Release hold for one cycle; next cycle restores it.
                        else if (step_ev && !at_lim_cur)
                            hold <= 1'b0;
`endif
                        else
                            hold <= 1'b1;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        ena     <= 1'b0;
                        hold    <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign state = state_q;
endmodule
